// File: rtl/vga_pixel_pipeline.sv
`timescale 1ns/1ps
// Two-stage pixel pipeline behind the VGA timing controller: draws a border and a
// box that bounces once per frame (on the vsync falling edge), with aligned sync/enable.
module vga_pixel_pipeline #(
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned BOX_SIZE      = 32,
  parameter int unsigned STEP          = 2,
  parameter int unsigned BORDER_W      = 4,
  parameter logic [11:0] BORDER_COLOUR = 12'hFFF,
  parameter logic [11:0] BOX_COLOUR    = 12'hF00,
  parameter logic [11:0] BG_COLOUR     = 12'h00F
) (
  input  logic       Master_Clock_In,
  input  logic       Reset_N_In,
  input  logic       Sync_Horiz_In,
  input  logic       Sync_Vert_In,
  input  logic       Disp_Ena_In,
  input  logic [9:0] Val_Col_In,
  input  logic [9:0] Val_Row_In,
  input  logic       Pause_In,
  output logic       Sync_Horiz_Out,
  output logic       Sync_Vert_Out,
  output logic       Disp_Ena_Out,
  output logic [11:0] RGB_Out,
  output logic [9:0] Box_X_Out,
  output logic [9:0] Box_Y_Out
);

  localparam int unsigned PW = 10;
  localparam int unsigned WW = 11;

  localparam logic [WW-1:0] BORDER_LO = WW'(BORDER_W);
  localparam logic [WW-1:0] BORDER_HX = WW'(H_ACTIVE - BORDER_W);
  localparam logic [WW-1:0] BORDER_HY = WW'(V_ACTIVE - BORDER_W);
  localparam logic [WW-1:0] BOX_W     = WW'(BOX_SIZE);
  localparam logic [WW-1:0] X_LIMIT   = WW'(H_ACTIVE - BOX_SIZE);
  localparam logic [WW-1:0] Y_LIMIT   = WW'(V_ACTIVE - BOX_SIZE);
  localparam logic [WW-1:0] STEP_W    = WW'(STEP);
  localparam logic [PW-1:0] STEP_P    = PW'(STEP);

  logic          s1_hs, s1_vs, s1_de;
  logic [PW-1:0] s1_col, s1_row;
  logic          vs_hist, primed;
  logic          x_dir, y_dir;
  logic          tick_c;
  logic [11:0]   colour_c;
  logic [WW-1:0] x_next_c, y_next_c;
  logic [WW-1:0] col_w, row_w, bx_w, by_w;

  // Stage 1: capture the timing inputs.
  always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      s1_hs  <= 1'b1;
      s1_vs  <= 1'b1;
      s1_de  <= 1'b0;
      s1_col <= '0;
      s1_row <= '0;
    end else begin
      s1_hs  <= Sync_Horiz_In;
      s1_vs  <= Sync_Vert_In;
      s1_de  <= Disp_Ena_In;
      s1_col <= Val_Col_In;
      s1_row <= Val_Row_In;
    end
  end

  assign col_w = {1'b0, s1_col};
  assign row_w = {1'b0, s1_row};
  assign bx_w  = {1'b0, Box_X_Out};
  assign by_w  = {1'b0, Box_Y_Out};

  // Colour selection, border first, then box, then background.
  always_comb begin
    colour_c = BG_COLOUR;
    if (col_w < BORDER_LO || col_w >= BORDER_HX || row_w < BORDER_LO || row_w >= BORDER_HY)
      colour_c = BORDER_COLOUR;
    else if (col_w >= bx_w && col_w < bx_w + BOX_W && row_w >= by_w && row_w < by_w + BOX_W)
      colour_c = BOX_COLOUR;
  end

  // Stage 2: registered colour with sync/enable kept in step.
  always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      Sync_Horiz_Out <= 1'b1;
      Sync_Vert_Out  <= 1'b1;
      Disp_Ena_Out   <= 1'b0;
      RGB_Out        <= '0;
    end else begin
      Sync_Horiz_Out <= s1_hs;
      Sync_Vert_Out  <= s1_vs;
      Disp_Ena_Out   <= s1_de;
      RGB_Out        <= s1_de ? colour_c : 12'h000;
    end
  end

  // primed blocks a tick on the first cycle out of reset when vsync is already low.
  assign tick_c = vs_hist & ~Sync_Vert_In & primed;

  // Returns {direction, position} for one axis after a motion step.
  function automatic logic [WW-1:0] axis_next(input logic [PW-1:0] pos, input logic dir,
                                              input logic [WW-1:0] limit);
    logic [WW-1:0] p;
    p = {1'b0, pos};
    axis_next = {dir, pos};
    if (dir) begin
      if (p + STEP_W >= limit) axis_next = {1'b0, limit[PW-1:0]};
      else                     axis_next = {1'b1, pos + STEP_P};
    end else begin
      if (p <= STEP_W) axis_next = {1'b1, {PW{1'b0}}};
      else             axis_next = {1'b0, pos - STEP_P};
    end
  endfunction

  always_comb begin
    x_next_c = {x_dir, Box_X_Out};
    y_next_c = {y_dir, Box_Y_Out};
    if (tick_c && !Pause_In) begin
      x_next_c = axis_next(Box_X_Out, x_dir, X_LIMIT);
      y_next_c = axis_next(Box_Y_Out, y_dir, Y_LIMIT);
    end
  end

  // Frame-edge detection and box position state.
  always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      vs_hist   <= 1'b1;
      primed    <= 1'b0;
      x_dir     <= 1'b1;
      y_dir     <= 1'b1;
      Box_X_Out <= '0;
      Box_Y_Out <= '0;
    end else begin
      vs_hist   <= Sync_Vert_In;
      primed    <= 1'b1;
      x_dir     <= x_next_c[WW-1];
      y_dir     <= y_next_c[WW-1];
      Box_X_Out <= x_next_c[PW-1:0];
      Box_Y_Out <= y_next_c[PW-1:0];
    end
  end

endmodule

// File: tb/tb_vga_pixel_pipeline.sv
`timescale 1ns/1ps
// Scoreboard bench for vga_pixel_pipeline: the driver predicts each pixel from a
// closed-form box trajectory, a monitor compares outputs two clocks later.
module tb_vga_pixel_pipeline;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hs_in, vs_in, de_in, pause;
  logic [9:0]  col_in, row_in;
  logic        hs_out, vs_out, de_out;
  logic [11:0] rgb;
  logic [9:0]  box_x, box_y;

  vga_pixel_pipeline dut (
    .Master_Clock_In(clk), .Reset_N_In(rst_n),
    .Sync_Horiz_In(hs_in), .Sync_Vert_In(vs_in), .Disp_Ena_In(de_in),
    .Val_Col_In(col_in), .Val_Row_In(row_in), .Pause_In(pause),
    .Sync_Horiz_Out(hs_out), .Sync_Vert_Out(vs_out), .Disp_Ena_Out(de_out),
    .RGB_Out(rgb), .Box_X_Out(box_x), .Box_Y_Out(box_y)
  );

  always #20 clk = ~clk;

  typedef struct {
    int          due;
    logic        hs, vs, de;
    logic [11:0] rgb;
    int          col, row;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_ticks = 0;
  bit   prev_vs = 1'b1;
  bit   first_cycle = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Box position after n unpaused ticks: a triangle wave between 0 and limit.
  function automatic int tri_pos(input int n, input int limit);
    int half;
    int m;
    half = limit / 2;
    m = n % (2 * half);
    return (m <= half) ? 2 * m : 2 * (2 * half - m);
  endfunction

  function automatic logic [11:0] ref_colour(input int col, input int row, input int bx, input int by);
    if (col < 4 || col >= 636 || row < 4 || row >= 476) return 12'hFFF;
    if (col >= bx && col < bx + 32 && row >= by && row < by + 32) return 12'hF00;
    return 12'h00F;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic drive(input bit hs, input bit vs, input bit de, input int col, input int row,
                       input bit pz, input bit release_rst);
    exp_t e;
    @(negedge clk);
    if (release_rst) begin
      rst_n = 1'b1;
      first_cycle = 1'b1;
    end
    hs_in = hs; vs_in = vs; de_in = de; pause = pz;
    col_in = 10'(col); row_in = 10'(row);
    if (!first_cycle && prev_vs && !vs && !pz) n_ticks++;
    prev_vs = vs;
    first_cycle = 1'b0;
    e.due = cyc + 2;
    e.hs = hs; e.vs = vs; e.de = de; e.col = col; e.row = row;
    e.rgb = de ? ref_colour(col, row, tri_pos(n_ticks, 608), tri_pos(n_ticks, 448)) : 12'h000;
    sb.push_back(e);
  endtask

  task automatic drive_rand(input bit vs, input bit pz);
    drive(1'($urandom_range(0, 1)), vs, 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 799)), int'($urandom_range(0, 524)), pz, 1'b0);
  endtask

  task automatic tick(input bit pz);
    drive_rand(1'b1, pz);
    drive_rand(1'b0, pz);
  endtask

  task automatic check_box(input string name);
    @(posedge clk);
    #1;
    chk({name, "_x"}, int'(box_x), tri_pos(n_ticks, 608));
    chk({name, "_y"}, int'(box_y), tri_pos(n_ticks, 448));
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    sb.delete();
    n_ticks = 0;
    prev_vs = 1'b1;
  endtask

  // Monitor: compares every prediction that falls due on this cycle.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        mon_e = sb.pop_front();
        checks++;
        if (mon_e.due != cyc || hs_out !== mon_e.hs || vs_out !== mon_e.vs ||
            de_out !== mon_e.de || rgb !== mon_e.rgb) begin
          errors++;
          $display("FAIL pixel col=%0d row=%0d got hs=%b vs=%b de=%b rgb=%h want hs=%b vs=%b de=%b rgb=%h",
                   mon_e.col, mon_e.row, hs_out, vs_out, de_out, rgb,
                   mon_e.hs, mon_e.vs, mon_e.de, mon_e.rgb);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    hs_in = 1'b1; vs_in = 1'b1; de_in = 1'b1; pause = 1'b0;
    col_in = 10'd100; row_in = 10'd100;
    repeat (3) @(negedge clk);
    chk("reset_rgb", int'(rgb), 0);
    chk("reset_hs", int'(hs_out), 1);
    chk("reset_vs", int'(vs_out), 1);
    chk("reset_de", int'(de_out), 0);
    chk("reset_box_x", int'(box_x), 0);
    chk("reset_box_y", int'(box_y), 0);

    drive(1'b1, 1'b1, 1'b1, 100, 100, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("rgb_first_edge", int'(rgb), 0);

    drive(1'b0, 1'b1, 1'b1, 2, 10, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 10, 10, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 636, 200, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 32, 10, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 10, 10, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 3, 479, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 31, 31, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 635, 475, 1'b0, 1'b0);
    repeat (200) drive_rand(1'b1, 1'b0);

    drive_rand(1'b0, 1'b0);
    check_box("tick1");
    chk("tick1_lit_x", int'(box_x), 2);
    chk("tick1_lit_y", int'(box_y), 2);
    repeat (100) drive_rand(1'b0, 1'b0);
    check_box("vs_held");

    repeat (223) tick(1'b0);
    check_box("tick224");
    chk("tick224_lit_y", int'(box_y), 448);
    tick(1'b0);
    check_box("tick225");
    chk("tick225_lit_y", int'(box_y), 446);
    repeat (79) tick(1'b0);
    check_box("tick304");
    chk("tick304_lit_x", int'(box_x), 608);
    tick(1'b0);
    check_box("tick305");
    chk("tick305_lit_x", int'(box_x), 606);

    repeat (10) tick(1'b1);
    check_box("paused");
    chk("paused_lit_x", int'(box_x), 606);
    tick(1'b0);
    check_box("resumed");
    chk("resumed_lit_x", int'(box_x), 604);

    @(negedge clk);
    assert_reset();
    repeat (2) @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 100, 100, 1'b0, 1'b1);
    repeat (25) tick(1'b0);
    check_box("pre_reset");
    chk("pre_reset_lit_x", int'(box_x), 50);
    drive(1'b0, 1'b0, 1'b1, 60, 60, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 60, 60, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 60, 60, 1'b0, 1'b0);
    @(negedge clk);
    #5;
    assert_reset();
    #1;
    chk("async_box_x", int'(box_x), 0);
    chk("async_box_y", int'(box_y), 0);
    chk("async_rgb", int'(rgb), 0);
    chk("async_hs", int'(hs_out), 1);
    chk("async_vs", int'(vs_out), 1);
    chk("async_de", int'(de_out), 0);
    repeat (2) @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 40, 40, 1'b0, 1'b1);
    repeat (20) drive_rand(1'b0, 1'b0);
    check_box("no_tick_release");
    chk("no_tick_release_lit_x", int'(box_x), 0);
    tick(1'b0);
    check_box("after_release_tick");
    repeat (50) drive_rand(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_pixel_pipeline.md
Name: vga_pixel_pipeline

Overview:
- Downstream stage of VGA_Controller, fed directly by its sync, display-enable and column/row outputs.
- Produces registered 12-bit RGB (4:4:4), plus sync and enable delayed to stay aligned with the RGB.
- Draws a fixed screen border and a square box that bounces around the active area. The box moves once per frame, during vertical sync.

Parameters:
- H_ACTIVE, 640, active columns
- V_ACTIVE, 480, active rows
- BOX_SIZE, 32, box edge length in pixels
- STEP, 2, pixels moved per frame on each axis
- BORDER_W, 4, border thickness in pixels
- BORDER_COLOUR, 12'hFFF, border RGB
- BOX_COLOUR, 12'hF00, box RGB
- BG_COLOUR, 12'h00F, background RGB

Ports:
- Master_Clock_In  in  1  25 MHz pixel clock
- Reset_N_In  in  1  asynchronous, active-low reset
- Sync_Horiz_In  in  1  hsync from controller, active-low
- Sync_Vert_In  in  1  vsync from controller, active-low
- Disp_Ena_In  in  1  current pixel is in the active area
- Val_Col_In  in  10  current column
- Val_Row_In  in  10  current row
- Pause_In  in  1  when 1, suppresses box motion
- Sync_Horiz_Out  out  1  hsync delayed 2 cycles
- Sync_Vert_Out  out  1  vsync delayed 2 cycles
- Disp_Ena_Out  out  1  enable delayed 2 cycles
- RGB_Out  out  12  pixel colour, {R[3:0],G[3:0],B[3:0]}
- Box_X_Out  out  10  box left edge
- Box_Y_Out  out  10  box top edge

Behaviour:
- Reset values: syncs 1, Disp_Ena_Out 0, RGB_Out 0, Box_X/Y 0, both directions +, vsync-history register 1, all pipeline registers 0 except the sync stages, which reset to 1. Assertion takes effect immediately, mid-frame included.
- Pipeline, stage 1: registers all timing inputs.
- Pipeline, stage 2: computes colour from the stage-1 values; registers RGB and the stage-1 sync/enable.
- Latency: exactly 2 clock edges from input to output, for all outputs.
- Blanking: when the stage-1 enable is 0, RGB_Out is 12'h000.
- Colour priority, first match wins:
  - Border: col < BORDER_W, col >= H_ACTIVE-BORDER_W, row < BORDER_W, or row >= V_ACTIVE-BORDER_W gives BORDER_COLOUR.
  - Box: Box_X <= col < Box_X+BOX_SIZE and Box_Y <= row < Box_Y+BOX_SIZE gives BOX_COLOUR.
  - Otherwise BG_COLOUR.
- Width rule: all additions and comparisons use 11 bits, so nothing wraps.
- Frame tick: a one-cycle pulse when the vsync history is 1 and Sync_Vert_In is 0, i.e. the falling edge of the raw input.
- No spurious tick:
  - when vsync is held low;
  - on the first cycle after reset when vsync is already low.
- Motion on a tick with Pause_In=0 (Pause_In is sampled on the tick cycle). Per axis, LIMIT = H_ACTIVE-BOX_SIZE for X and V_ACTIVE-BOX_SIZE for Y:
  - Direction + with pos+STEP >= LIMIT: pos = LIMIT, direction becomes −.
  - Direction − with pos <= STEP: pos = 0, direction becomes +.
  - Otherwise: pos ± STEP.
  - Each axis updates independently in the same cycle.
- Tick with Pause_In=1: position and direction are unchanged.
- New position is visible on Box_X/Y_Out one cycle after the tick. It is used for colour on the next pixel entering stage 2.
- Ticks occur during blanking, so no tearing within a frame.

Test Plan:
- Hold reset low, then release with Disp_Ena_In=1, col=100, row=100 → RGB_Out 000 until the 2nd rising edge after release, then 00F. Sync outputs are 1 during reset.
- Drive, each sampled 2 cycles later:
  - col=2, row=10 → FFF, border beats box;
  - col=10, row=10 → F00;
  - col=636, row=200 → FFF;
  - col=32, row=10 → 00F;
  - Disp_Ena_In=0 at col=10 → 000.
- Apply 1 vsync falling edge with Pause_In=0 → Box_X=2, Box_Y=2. Hold vsync low for 100 cycles → no further change.
- Apply 224 ticks → Y=448, direction flips; tick 225 → Y=446. Apply 304 ticks total → X=608; tick 305 → X=606.
- Set Pause_In=1 across 10 ticks → position frozen. Deassert → motion resumes from the same position.
- Assert reset mid-frame with Box_X=50 → Box_X/Y=0, RGB=0, syncs=1 asynchronously. No tick is generated on release while vsync is low.
